// File: rtl/stim_gen_pkg.sv
// Shared definitions for the operand stimulus source: state encoding, LFSR taps,
// corner count and small pure helpers used by the top and the LFSR sub-module.
package stim_gen_pkg;

   localparam int unsigned CORNER_CNT = 32'd4;
   // Feedback taps 32,22,2,1 expressed as bit positions 31,21,1,0.
   localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {s[30:0], ^(s & LFSR_TAPS)};
   endfunction

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   function automatic logic [31:0] seed_fix(input logic [31:0] s);
      return (s == 32'd0) ? 32'd1 : s;
   endfunction

   // Corners in order: (0,0) (MAX,MAX) (0,MAX) (MAX,0).
   function automatic logic [31:0] corner_a(input logic [1:0] k);
      return k[0] ? {32{1'b1}} : 32'd0;
   endfunction

   function automatic logic [31:0] corner_b(input logic [1:0] k);
      return (k[0] ^ k[1]) ? {32{1'b1}} : 32'd0;
   endfunction

endpackage

// File: rtl/stim_gen_if.sv
// Valid/ready operand-pair stream between the stimulus source (master) and the DUT (slave).
interface stim_gen_if #(
   parameter int WIDTH = 32
) ();

   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;

   modport master (output valid, output op_a, output op_b, input ready);
   modport slave  (input valid, input op_a, input op_b, output ready);

endinterface

// File: rtl/stim_gen_lfsr32.sv
// 32-bit Fibonacci LFSR with seed load and single-step advance; also exposes the
// value it would take after one advance so the caller can present it without a bubble.
module stim_gen_lfsr32
   import stim_gen_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_seed,
   input  logic        i_load,
   input  logic        i_advance,
   output logic [31:0] o_state,
   output logic [31:0] o_state_nxt
);

   logic [31:0] state_d;
   logic [31:0] state_q;

   // Load has priority over advance.
   always_comb begin
      state_d = state_q;
      if (i_load) begin
         state_d = i_seed;
      end else if (i_advance) begin
         state_d = lfsr_next(state_q);
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= i_seed;
      end else begin
         state_q <= state_d;
      end
   end

   assign o_state     = state_q;
   assign o_state_nxt = lfsr_next(state_q);

endmodule

// File: rtl/stim_gen.sv
// Operand stimulus source: N operand pairs (optional directed corners, then two LFSR
// streams) on a valid/ready stream, with start/abort run control and a transfer counter.
module stim_gen
   import stim_gen_pkg::*;
#(
   parameter int          WIDTH   = 32,
   parameter logic [31:0] SEED_A  = 32'h0000_0001,
   parameter logic [31:0] SEED_B  = 32'h0000_ACE1,
   parameter bit          CORNERS = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   input  logic [31:0] i_num_vec,
   input  logic        i_abort,
   stim_gen_if.master  stream,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_sent_ctr
);

   localparam logic [31:0] SEED_A_FIX = seed_fix(SEED_A);
   localparam logic [31:0] SEED_B_FIX = seed_fix(SEED_B);

   state_e           state_d, state_q;
   logic [31:0]      idx_d, idx_q;
   logic [31:0]      last_d, last_q;
   logic [31:0]      sent_d, sent_q;
   logic             valid_d, valid_q;
   logic             busy_d, busy_q;
   logic             done_d, done_q;
   logic [WIDTH-1:0] op_a_d, op_a_q;
   logic [WIDTH-1:0] op_b_d, op_b_q;

   logic             xfer_s;
   logic             load_s;
   logic             adv_s;
   logic             cur_corner_s;
   logic [31:0]      nxt_idx_s;
   logic [31:0]      lfsr_a_s, lfsr_a_nxt_s;
   logic [31:0]      lfsr_b_s, lfsr_b_nxt_s;
   logic [31:0]      nxt_a_s, nxt_b_s;
   logic [31:0]      first_a_s, first_b_s;

   assign xfer_s       = valid_q & stream.ready;
   assign load_s       = i_start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   assign cur_corner_s = CORNERS && (idx_q < CORNER_CNT);
   // LFSRs step only when a random vector is consumed, so the first random vector is the seed.
   assign adv_s        = xfer_s & (state_q == ST_RUN) & ~cur_corner_s;
   assign nxt_idx_s    = idx_q + 32'd1;
   assign first_a_s    = CORNERS ? corner_a(2'd0) : SEED_A_FIX;
   assign first_b_s    = CORNERS ? corner_b(2'd0) : SEED_B_FIX;

   stim_gen_lfsr32 u_lfsr_a (
      .clk         (clk),
      .reset       (reset),
      .i_seed      (SEED_A_FIX),
      .i_load      (load_s),
      .i_advance   (adv_s),
      .o_state     (lfsr_a_s),
      .o_state_nxt (lfsr_a_nxt_s)
   );

   stim_gen_lfsr32 u_lfsr_b (
      .clk         (clk),
      .reset       (reset),
      .i_seed      (SEED_B_FIX),
      .i_load      (load_s),
      .i_advance   (adv_s),
      .o_state     (lfsr_b_s),
      .o_state_nxt (lfsr_b_nxt_s)
   );

   // Operand pair that follows the current one, taking the same-cycle LFSR step into account.
   always_comb begin
      nxt_a_s = lfsr_a_s;
      nxt_b_s = lfsr_b_s;
      if (CORNERS && (nxt_idx_s < CORNER_CNT)) begin
         nxt_a_s = corner_a(nxt_idx_s[1:0]);
         nxt_b_s = corner_b(nxt_idx_s[1:0]);
      end else if (adv_s) begin
         nxt_a_s = lfsr_a_nxt_s;
         nxt_b_s = lfsr_b_nxt_s;
      end else begin
         nxt_a_s = lfsr_a_s;
         nxt_b_s = lfsr_b_s;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      sent_d  = sent_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = done_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (i_start) begin
               idx_d  = 32'd0;
               last_d = i_num_vec - 32'd1;
               sent_d = 32'd0;
               if (i_num_vec != 32'd0) begin
                  state_d = ST_RUN;
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
                  done_d  = 1'b0;
                  op_a_d  = first_a_s[WIDTH-1:0];
                  op_b_d  = first_b_s[WIDTH-1:0];
               end else begin
                  state_d = ST_DONE;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (xfer_s) begin
               sent_d = sent_q + 32'd1;
            end else begin
               sent_d = sent_q;
            end
            // Abort wins over everything else; a transfer in the abort cycle is still counted above.
            if (i_abort || (xfer_s && (idx_q == last_q))) begin
               state_d = ST_DONE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (xfer_s) begin
               idx_d  = nxt_idx_s;
               op_a_d = nxt_a_s[WIDTH-1:0];
               op_b_d = nxt_b_s[WIDTH-1:0];
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= 32'd0;
         last_q  <= 32'd0;
         sent_q  <= 32'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         op_a_q  <= {WIDTH{1'b0}};
         op_b_q  <= {WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         sent_q  <= sent_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
      end
   end

   assign stream.valid = valid_q;
   assign stream.op_a  = op_a_q;
   assign stream.op_b  = op_b_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_sent_ctr   = sent_q;

endmodule
